// File: rtl/memory_ctrl_if.sv
// rtl/memory_ctrl_if.sv - request/response handshake bundle for memory_ctrl
// wr_err exists only when MEMORY_CTRL_VERIFY_EN is defined.
interface memory_ctrl_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DWIDTH-1:0] rsp_data;
  logic              wr_done;
`ifdef MEMORY_CTRL_VERIFY_EN
  logic              wr_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, wr_done, wr_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, wr_done, wr_err
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, wr_done
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, wr_done
  );
`endif
endinterface

// File: rtl/memory_ctrl.sv
// rtl/memory_ctrl.sv - strobe sequencer for the 32x8 asynchronous memory
// Optional write read-back check enabled by MEMORY_CTRL_VERIFY_EN.
module memory_ctrl #(
  parameter int DWIDTH  = 8,
  parameter int AWIDTH  = 5,
  parameter int RD_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  memory_ctrl_if.slave      bus,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  inout  wire  [DWIDTH-1:0] mem_data
);

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_STROBE,
    RD_RESP
`ifdef MEMORY_CTRL_VERIFY_EN
    , WR_VERIFY
`endif
  } state_t;

  localparam logic [3:0] RD_WAIT_C = 4'(RD_WAIT);

  state_t            state_q;
  logic              ready_q;
  logic              rsp_valid_q;
  logic              wr_done_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              drive_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [DWIDTH-1:0] rsp_data_q;
  logic [3:0]        cnt_q;
`ifdef MEMORY_CTRL_VERIFY_EN
  logic              wr_err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      wr_done_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      drive_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_data_q  <= '0;
      cnt_q       <= '0;
`ifdef MEMORY_CTRL_VERIFY_EN
      wr_err_q    <= 1'b0;
`endif
    end else begin
      wr_done_q <= 1'b0;
`ifdef MEMORY_CTRL_VERIFY_EN
      wr_err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (bus.req_valid && ready_q) begin
            ready_q <= 1'b0;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            if (bus.req_we) begin
              drive_q <= 1'b1;
              state_q <= WR_SETUP;
            end else begin
              mem_read_q <= 1'b1;
              cnt_q      <= RD_WAIT_C;
              state_q    <= RD_STROBE;
            end
          end
        end
        WR_SETUP: begin
          mem_write_q <= 1'b1;
          state_q     <= WR_PULSE;
        end
        WR_PULSE: begin
          mem_write_q <= 1'b0;
          state_q     <= WR_HOLD;
        end
        WR_HOLD: begin
          drive_q <= 1'b0;
`ifdef MEMORY_CTRL_VERIFY_EN
          mem_read_q <= 1'b1;
          cnt_q      <= RD_WAIT_C;
          state_q    <= WR_VERIFY;
`else
          wr_done_q <= 1'b1;
          ready_q   <= 1'b1;
          state_q   <= IDLE;
`endif
        end
`ifdef MEMORY_CTRL_VERIFY_EN
        WR_VERIFY: begin
          if (cnt_q == 4'd0) begin
            mem_read_q <= 1'b0;
            wr_done_q  <= 1'b1;
            wr_err_q   <= (mem_data != wdata_q);
            ready_q    <= 1'b1;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
`endif
        RD_STROBE: begin
          // Sample on the last strobe edge, while the memory is still driving.
          if (cnt_q == 4'd0) begin
            rsp_data_q  <= mem_data;
            mem_read_q  <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RD_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RD_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          drive_q     <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.wr_done   = wr_done_q;
`ifdef MEMORY_CTRL_VERIFY_EN
  assign bus.wr_err    = wr_err_q;
`endif

  assign mem_addr  = addr_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_data  = drive_q ? wdata_q : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_memory_ctrl.sv
// tb/tb_memory_ctrl.sv - self-checking bench for memory_ctrl
// Covers the MEMORY_CTRL_VERIFY_EN build as well when that macro is defined.
`timescale 1ns/1ps
module tb_memory_ctrl;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int RW = 1;
`ifdef MEMORY_CTRL_VERIFY_EN
  localparam int WR_LEN = 5 + RW;
`else
  localparam int WR_LEN = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  memory_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus();
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic          mem_write;
  wire  [DW-1:0] mem_data;

  memory_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .RD_WAIT(RW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mem_addr (mem_addr),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_data (mem_data)
  );

  always #5 clk = ~clk;

  // Strobe memory plus a probe driver used to detect an undriven bus.
  logic [DW-1:0] mem_arr [0:31];
  logic          probe_en = 1'b0;
  logic [DW-1:0] probe_val = '0;
  assign mem_data = mem_read ? mem_arr[mem_addr] : {DW{1'bz}};
  assign mem_data = probe_en ? probe_val : {DW{1'bz}};

  initial begin
    for (int i = 0; i < 32; i++) mem_arr[i] = '0;
    forever begin
      @(posedge mem_write);
      mem_arr[mem_addr] = mem_data;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: k counts cycles since the accept edge.
  logic [DW-1:0] ref_mem [0:31];
  bit            ref_known [0:31];
  bit            m_busy = 1'b0;
  bit            m_we = 1'b0;
  bit            m_done = 1'b0;
  bit            m_err = 1'b0;
  bit            m_force = 1'b0;
  int            m_k = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  initial begin
    for (int i = 0; i < 32; i++) begin
      ref_mem[i]   = '0;
      ref_known[i] = 1'b1;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        if (m_busy && m_we) ref_known[m_addr] = 1'b0;
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_k = 0;
      end else begin
        cyc++;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!m_busy) begin
          if (bus.req_valid) begin
            m_busy = 1'b1; m_we = bus.req_we; m_addr = bus.req_addr;
            m_data = bus.req_wdata; m_k = 1; m_force = 1'b0;
          end
        end else if (m_we) begin
          if (probe_en && m_k >= 4) m_force = 1'b1;
          if (m_k == WR_LEN - 1) begin
            m_busy = 1'b0; m_done = 1'b1; m_err = m_force;
            ref_mem[m_addr] = m_data; ref_known[m_addr] = 1'b1;
          end else begin
            m_k++;
          end
        end else begin
          if (m_k >= RW + 2 && bus.rsp_ready) m_busy = 1'b0;
          else if (m_k < RW + 2) m_k++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("req_ready", 32'(bus.req_ready), 32'(!m_busy));
        chk("mem_write", 32'(mem_write), 32'(m_busy && m_we && m_k == 2));
        chk("mem_read", 32'(mem_read),
            32'(m_busy && ((!m_we && m_k <= RW + 1) || (m_we && m_k >= 4))));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_busy && !m_we && m_k >= RW + 2));
        chk("wr_done", 32'(bus.wr_done), 32'(m_done));
        chk("rd_wr_overlap", 32'(mem_read && mem_write), 32'd0);
        if (m_busy) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        if (m_busy && m_we && m_k <= 3) chk("wr_bus", 32'(mem_data), 32'(m_data));
        if (bus.rsp_valid && m_busy && !m_we && ref_known[m_addr])
          chk("rsp_data", 32'(bus.rsp_data), 32'(ref_mem[m_addr]));
`ifdef MEMORY_CTRL_VERIFY_EN
        chk("wr_err", 32'(bus.wr_err), 32'(m_err));
`endif
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rand_rdy) bus.rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit hold, output int acc);
    bit done = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
    for (int t = 0; t < 200 && !done; t++) begin
      done = bus.req_ready;
      tick();
    end
    chk("accept_in_time", 32'(done), 32'd1);
    acc = cyc;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_valid(input int acc, output int idx);
    idx = -1;
    for (int t = 0; t < 40; t++) begin
      if (bus.rsp_valid) begin
        idx = cyc - acc + 1;
        break;
      end
      tick();
    end
  endtask

  task automatic read_chk(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    int acc, idx;
    do_req(1'b0, a, '0, 1'b0, acc);
    wait_valid(acc, idx);
    chk("read_latency", 32'(idx), 32'(RW + 2));
    chk("read_value", 32'(bus.rsp_data), 32'(exp));
    tick();
    chk("one_cycle_rsp", 32'(bus.rsp_valid), 32'd0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, acc2, nw, nd, dc, idx;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_wr_done", 32'(bus.wr_done), 32'd0);
    chk("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    rst = 1'b0;
    tick();

    // Write 0xA5 @3, then read it back.
    do_req(1'b1, 5'd3, 8'hA5, 1'b0, acc);
    nw = 0; nd = 0; dc = -1;
    for (int i = 0; i < 8; i++) begin
      if (mem_write) nw++;
      if (bus.wr_done) begin nd++; dc = cyc - acc + 1; end
      tick();
    end
    chk("write_pulses", 32'(nw), 32'd1);
    chk("wr_done_count", 32'(nd), 32'd1);
    chk("wr_done_cycle", 32'(dc), 32'(WR_LEN));
    read_chk(5'd3, 8'hA5);

    // Back-to-back writes with req_valid held high, including top address.
    do_req(1'b1, 5'd0, 8'h11, 1'b1, acc);
    do_req(1'b1, 5'd31, 8'h22, 1'b0, acc2);
    chk("b2b_spacing", 32'(acc2 - acc), 32'(WR_LEN));
    repeat (WR_LEN + 1) tick();
    read_chk(5'd0, 8'h11);
    read_chk(5'd31, 8'h22);

    // Response backpressure for 5 cycles.
    bus.rsp_ready = 1'b0;
    do_req(1'b0, 5'd3, '0, 1'b0, acc);
    wait_valid(acc, idx);
    chk("bp_latency", 32'(idx), 32'(RW + 2));
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_data", 32'(bus.rsp_data), 32'hA5);
      chk("bp_ready_low", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
    chk("bp_release_ready", 32'(bus.req_ready), 32'd1);

    // Reset during WR_PULSE.
    do_req(1'b1, 5'd7, 8'h5A, 1'b0, acc);
    for (int t = 0; t < 10 && !mem_write; t++) tick();
    chk("pulse_reached", 32'(mem_write), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_write", 32'(mem_write), 32'd0);
    chk("rst_mid_read", 32'(mem_read), 32'd0);
    probe_en = 1'b1; probe_val = 8'hC3;
    #1;
    chk("rst_bus_released", 32'(mem_data), 32'hC3);
    probe_en = 1'b0;
    chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    rst = 1'b0;
    tick();

`ifdef MEMORY_CTRL_VERIFY_EN
    // Corrupt the verify read of a 0x3C write, then a clean write.
    do_req(1'b1, 5'd9, 8'h3C, 1'b0, acc);
    for (int t = 0; t < 10 && !mem_read; t++) tick();
    probe_en = 1'b1; probe_val = 8'hFF;
    for (int t = 0; t < 20 && !bus.wr_done; t++) tick();
    chk("verify_done", 32'(bus.wr_done), 32'd1);
    chk("verify_err", 32'(bus.wr_err), 32'd1);
    probe_en = 1'b0;
    tick();
    do_req(1'b1, 5'd9, 8'h3C, 1'b0, acc);
    for (int t = 0; t < 20 && !bus.wr_done; t++) tick();
    chk("clean_done", 32'(bus.wr_done), 32'd1);
    chk("clean_err", 32'(bus.wr_err), 32'd0);
    tick();
`endif

    // Random sweep with random response backpressure.
    rand_rdy = 1'b1;
    for (int n = 0; n < 200; n++) begin
      do_req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             8'($urandom_range(0, 255)), 1'b0, acc);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_rdy = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/memory_ctrl.md
Name: memory_ctrl

Overview:
- Bus-master sequencer directly upstream of the 32x8 asynchronous strobe memory.
- Converts a synchronous valid/ready request stream into the memory's `addr`, `read`, `write` strobes and bidirectional `data` bus.
- Returns read data on a valid/ready response channel.
- Guarantees the memory's timing rules:
  - write capture happens on the rising edge of `write` with `read` low;
  - `read` and the controller's bus drive never overlap.

Parameters:
- DWIDTH, 8, data bus width.
- AWIDTH, 5, address width (depth 2**AWIDTH).
- RD_WAIT, 1, extra cycles `mem_read` is held before sampling (0..15).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request (high only in IDLE).
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  AWIDTH  request address.
- req_wdata  input  DWIDTH  write data.
- rsp_valid  output  1  read data valid.
- rsp_ready  input  1  consumer accepts read data.
- rsp_data  output  DWIDTH  read data.
- wr_done  output  1  one-cycle pulse when a write sequence completes.
- mem_addr  output  AWIDTH  memory address, registered.
- mem_read  output  1  memory read strobe, registered.
- mem_write  output  1  memory write strobe, registered, glitch-free.
- mem_data  inout  DWIDTH  memory data bus; driven only while drive enable is set, otherwise high-Z.

Behaviour:
- Reset (async, immediate) values:
  - State = IDLE; req_ready = 1; rsp_valid = 0; wr_done = 0.
  - mem_read = 0; mem_write = 0; drive enable = 0 (mem_data = Z).
  - mem_addr = 0; rsp_data = 0; wait counter = 0.
- Accept: a request is taken on a clk edge with req_valid && req_ready. req_addr, req_we and req_wdata are latched on that edge. Inputs are ignored outside IDLE.
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_STROBE, RD_RESP.
- Write path (accept at edge 0):
  - Cycle 1, WR_SETUP: mem_addr and mem_data driven, mem_write = 0.
  - Cycle 2, WR_PULSE: mem_write = 1; the memory captures on this rising edge.
  - Cycle 3, WR_HOLD: mem_write = 0; addr and data still driven.
  - Cycle 4: IDLE, drive released, wr_done = 1 for this one cycle.
  - A new request can be accepted at the end of cycle 4. Write throughput is 1 per 4 cycles.
- Read path (accept at edge 0):
  - RD_STROBE: mem_read = 1 for RD_WAIT+1 cycles (cycles 1..RD_WAIT+1); drive enable held 0.
  - rsp_data is sampled from mem_data on the last RD_STROBE edge.
  - RD_RESP: rsp_valid = 1 from cycle RD_WAIT+2, mem_read = 0. Hold rsp_valid and rsp_data stable until rsp_ready.
  - Return to IDLE on the edge where rsp_valid && rsp_ready.
- Invariants (assertion targets):
  - mem_read && mem_write never both 1.
  - Drive enable && mem_read never both 1.
  - mem_write is high for exactly one cycle per write.
  - mem_addr is stable throughout every sequence.
  - There is always at least one IDLE cycle between sequences, which serves as bus turnaround.
- Boundary conditions:
  - req_valid held high in a non-IDLE state: held off, not dropped or duplicated.
  - rsp_ready already high when rsp_valid rises: one-cycle response.
  - Address 2**AWIDTH-1: no wrap logic; passed through as-is.
  - RD_WAIT = 0: mem_read is high for 1 cycle.
- Reset mid-operation: all strobes drop asynchronously and the bus is released. A partially pulsed write may or may not land in memory; no recovery is attempted.

Optional Feature:
- Macro: MEMORY_CTRL_VERIFY_EN.
- When defined:
  - After WR_HOLD, the controller enters WR_VERIFY and performs an internal read of the same address (RD_WAIT+1 cycles of mem_read).
  - It compares the read value with the latched wdata.
  - wr_done then pulses; output wr_err (1 bit, reset 0) pulses in the same cycle if the values mismatch.
  - Write latency becomes 5+RD_WAIT cycles. rsp_valid is not asserted for verify reads.
- When undefined: no wr_err port, no WR_VERIFY state, and write latency is exactly 4 cycles.

Test Plan:
- Reset check: assert rst mid-write during WR_PULSE → mem_write is 0 and mem_data is Z within the same cycle; after release, req_ready = 1 and rsp_valid = 0.
- Write then read: write 0xA5 to addr 3, then read addr 3 → mem_write pulse exactly 1 cycle, wr_done once, rsp_data = 0xA5, rsp_valid at accept+3 (RD_WAIT=1).
- Back-to-back: req_valid held high with writes 0x11@0 then 0x22@31 → second accept 4 cycles after the first; reading 0 and 31 returns 0x11 and 0x22.
- Backpressure: read with rsp_ready = 0 for 5 cycles → rsp_valid and rsp_data stable for all 5 cycles, req_ready = 0 throughout; completes on the cycle rsp_ready rises.
- Bus safety sweep: 200 random requests with random rsp_ready → no read/write overlap, no drive during mem_read, and all read data matches a reference model.
- MEMORY_CTRL_VERIFY_EN: force a mismatched bus value during the verify read of a 0x3C write → wr_err pulses with wr_done; a normal write gives wr_err = 0.
